csr_hpm_counter_unit: RTL



---
 rtl/csr_hpm_counter_unit_if.sv | 29 ++
 rtl/csr_hpm_counter_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/csr_hpm_counter_unit_if.sv
// CSR access bus for the hardware performance counter unit.
//   csrNum       : CSR address of the current access (from master)
//   csrWE        : write strobe, only acted on when the address hits (from master)
//   csrWriteData : resolved write value (from master)
//   csrHit       : address decodes to a register in the unit (from slave)
//   csrReadData  : combinational read value, 0 on a miss (from slave)
interface csr_hpm_counter_unit_if;
    logic [11:0] csrNum;
    logic        csrWE;
    logic [31:0] csrWriteData;
    logic        csrHit;
    logic [31:0] csrReadData;

    modport master (
        output csrNum,
        output csrWE,
        output csrWriteData,
        input  csrHit,
        input  csrReadData
    );

    modport slave (
        input  csrNum,
        input  csrWE,
        input  csrWriteData,
        output csrHit,
        output csrReadData
    );
endinterface

// File: rtl/csr_hpm_counter_unit.sv
// Machine hardware performance counters mhpmcounter3.. with their mhpmevent
// selectors and the mcountinhibit register.
//   clk     : sole clock, rising edge
//   rst_n   : asynchronous active-low reset
//   csr     : CSR access bus (slave side); reads are combinational
//   eventIn : per-cycle event pulses, bit k is event k+1
//   ovfIrq  : registered overflow interrupt request (OR of OF & OVIE)
module csr_hpm_counter_unit #(
    parameter int NUM_COUNTERS  = 4,
    parameter int NUM_EVENTS    = 8,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    csr_hpm_counter_unit_if.slave   csr,
    input  logic [NUM_EVENTS-1:0]   eventIn,
    output logic                    ovfIrq
);
    localparam int          SW   = $clog2(NUM_EVENTS + 1);
    localparam int          HW   = COUNTER_WIDTH - 32;
    localparam logic [31:0] NE_U = 32'(NUM_EVENTS);

    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_d [NUM_COUNTERS];
    logic [SW-1:0]            sel_q [NUM_COUNTERS];
    logic [SW-1:0]            sel_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  of_q, of_d, ovie_q, ovie_d, inh_q, inh_d;
    logic                     irq_d;

    logic                     hit_inh;
    logic [NUM_COUNTERS-1:0]  hit_evt, hit_lo, hit_hi;
    logic [NUM_COUNTERS-1:0]  ev_hit, inc, wrap;
    logic [31:0]              rdata;
    logic [SW-1:0]            wsel;

    // Address decode
    always_comb begin
        hit_inh = (csr.csrNum == 12'h320);
        hit_evt = '0;
        hit_lo  = '0;
        hit_hi  = '0;
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            hit_evt[i] = (csr.csrNum == 12'(12'h323 + i));
            hit_lo[i]  = (csr.csrNum == 12'(12'hB03 + i));
            hit_hi[i]  = (csr.csrNum == 12'(12'hB83 + i));
        end
    end

    // Read mux on pre-edge state
    always_comb begin
        rdata = '0;
        if (hit_inh) rdata = 32'(inh_q) << 3;
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            if (hit_evt[i]) rdata = {of_q[i], ovie_q[i], 30'(sel_q[i])};
            if (hit_lo[i])  rdata = cnt_q[i][31:0];
            if (hit_hi[i])  rdata = 32'(cnt_q[i][COUNTER_WIDTH-1:32]);
        end
    end

    assign csr.csrHit      = hit_inh | (|hit_evt) | (|hit_lo) | (|hit_hi);
    assign csr.csrReadData = rdata;

    // Selected event is active; the loop form avoids indexing eventIn with a
    // selector wider than its range (WARL keeps sel within 0..NUM_EVENTS).
    always_comb begin
        ev_hit = '0;
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
                if (sel_q[i] == SW'(k + 1) && eventIn[k]) ev_hit[i] = 1'b1;
            end
        end
    end

    assign wsel = csr.csrWriteData[SW-1:0];

    // Next-state: increment first, then CSR writes override the written
    // fields; a wrap sets OF regardless of any same-cycle OF write.
    always_comb begin
        inc  = '0;
        wrap = '0;
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            cnt_d[i]  = cnt_q[i];
            sel_d[i]  = sel_q[i];
            of_d[i]   = of_q[i];
            ovie_d[i] = ovie_q[i];

            inc[i] = ev_hit[i] && !inh_q[i]
                     && !(csr.csrWE && (hit_lo[i] || hit_hi[i]));
            if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
                wrap[i]  = &cnt_q[i];
            end

            if (csr.csrWE && hit_lo[i]) cnt_d[i][31:0] = csr.csrWriteData;
            if (csr.csrWE && hit_hi[i]) cnt_d[i][COUNTER_WIDTH-1:32] = csr.csrWriteData[HW-1:0];

            if (csr.csrWE && hit_evt[i]) begin
                of_d[i]   = csr.csrWriteData[31];
                ovie_d[i] = csr.csrWriteData[30];
                sel_d[i]  = (32'(wsel) > NE_U) ? '0 : wsel;
            end
            of_d[i] = of_d[i] | wrap[i];
        end
        inh_d = (csr.csrWE && hit_inh) ? csr.csrWriteData[3 +: NUM_COUNTERS] : inh_q;
        irq_d = |(of_d & ovie_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            of_q   <= '0;
            ovie_q <= '0;
            inh_q  <= '0;
            ovfIrq <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            of_q   <= of_d;
            ovie_q <= ovie_d;
            inh_q  <= inh_d;
            ovfIrq <= irq_d;
        end
    end
endmodule
